button_conditioner: RTL and testbench
=====================================

# button_conditioner

Input-conditioning stage between the physical `btn1` pin and the game top level. It synchronises the raw push-button into the 27 MHz `clk` domain and debounces it. It then emits a clean level, single-cycle press and release pulses, and a long-press indication. `jump_controller` and game-restart logic consume these outputs instead of the bouncy pin.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 270000: consecutive stable cycles required to accept a level change (10 ms at 27 MHz). Must be ≥ 1.
- `LONG_PRESS_CYCLES`, 13500000: accepted-pressed cycles before long-press is flagged (500 ms). Must be ≥ 1.
- `BTN_ACTIVE_LOW`, 1: 1 = pin reads 0 when pressed (board default); 0 = active-high.

Ports:
- `clk` in 1: system clock, 27 MHz.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn_raw` in 1: asynchronous pin from the board.
- `btn_level` out 1: debounced state, 1 = pressed (always active-high).
- `press_pulse` out 1: one-cycle strobe on an accepted press.
- `release_pulse` out 1: one-cycle strobe on an accepted release.
- `long_pulse` out 1: one-cycle strobe when the hold reaches `LONG_PRESS_CYCLES`.
- `long_press` out 1: level, high from `long_pulse` until the accepted release.

## Operation
- **Synchroniser:** 2-flop. Both flops reset to the *released* pin value (`BTN_ACTIVE_LOW` ? 1 : 0), so reset never fabricates a press. The normalised sample is `p = sync2 XOR BTN_ACTIVE_LOW`.
- **FSM states:** RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK. Reset state is RELEASED.
  - RELEASED: if `p` = 1, go to PRESS_CHK with `dcnt` = 0.
  - PRESS_CHK: if `p` = 0, return to RELEASED (glitch rejected, no outputs). Otherwise, when `dcnt` = `DEBOUNCE_CYCLES`−1, go to PRESSED and assert `press_pulse`. Otherwise increment `dcnt`.
  - PRESSED: if `p` = 0, go to RELEASE_CHK with `dcnt` = 0. The hold counter keeps running.
  - RELEASE_CHK: if `p` = 1, return to PRESSED (hold counter not cleared). Otherwise, when `dcnt` = `DEBOUNCE_CYCLES`−1, go to RELEASED, assert `release_pulse`, and clear the hold counter and `long_press`.
- **`dcnt`:** width `$clog2(DEBOUNCE_CYCLES+1)`. It never wraps because every terminal compare precedes overflow.
- **Hold counter `hcnt`:**
  - Width `$clog2(LONG_PRESS_CYCLES+1)`.
  - Cleared on entry to PRESSED.
  - Increments every cycle in PRESSED and RELEASE_CHK.
  - Saturates at `LONG_PRESS_CYCLES`.
  - `long_pulse` fires on the cycle `hcnt` becomes `LONG_PRESS_CYCLES`, at most once per press.
- **`btn_level`:** 1 in PRESSED and RELEASE_CHK; 0 otherwise.
- **Pulse exclusivity:** `press_pulse` and `release_pulse` are mutually exclusive by construction. `long_pulse` never coincides with `press_pulse`, since `LONG_PRESS_CYCLES` ≥ 1.
- **Reset mid-operation:** all state and outputs clear immediately, with no release pulse. If the button is still held when `rst_n` deasserts, a fresh press is reported after normal debounce latency.

## Timing
- **Reset values:** all outputs 0; FSM = RELEASED; `dcnt` = `hcnt` = 0.
- **Outputs:** all registered, no combinational path from `btn_raw`.
- **Press latency:** `btn_raw` stably pressed from rising edge N gives `press_pulse` high in the cycle after edge N+2+`DEBOUNCE_CYCLES`. `btn_level` rises on that same edge.
- **Release latency:** identical, using `release_pulse`.
- **Long press:** `long_pulse` occurs `LONG_PRESS_CYCLES` cycles after `press_pulse`.
- **Glitch rejection:** any excursion shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no output change.
- **Pulse width:** every pulse is exactly 1 cycle wide.

## Structure
- **Shared include `dino_defs.vh`:**
  - `CLK_HZ` = 27000000.
  - FSM state encodings (2-bit: RELEASED=0, PRESS_CHK=1, PRESSED=2, RELEASE_CHK=3).
  - Default debounce and long-press constants, for reuse by other input blocks.
- **Sub-module `sync_2ff`:** generic 1-bit synchroniser with parameterised reset value. It is instantiated here and reusable for any future pin.
- **Top-level integration:** `top` routes `btn1` through this block. `jump_controller` takes `press_pulse`; `long_press` is available for restart.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `LONG_PRESS_CYCLES`=20, `BTN_ACTIVE_LOW`=1.

- **Clean press:** hold `btn_raw`=0 from edge 10 → `press_pulse` high for exactly one cycle after edge 16. `btn_level`=1 from that edge. No other pulses.
- **Bounce rejection:** toggle `btn_raw` 0/1 every 2 cycles for 40 cycles, then hold 1 → all outputs stay 0 throughout.
- **Long press:** hold pressed 40 cycles → `long_pulse` exactly once, 20 cycles after `press_pulse`. `long_press` high until `release_pulse`, which fires 6 cycles after `btn_raw` returns to 1.
- **Release glitch:** while PRESSED, drive `btn_raw`=1 for 3 cycles then 0 → no `release_pulse`, `btn_level` stays 1, hold count continues (`long_pulse` timing unchanged).
- **Reset mid-press:** assert `rst_n`=0 while `long_press`=1 → all outputs 0 asynchronously, no `release_pulse`. Deassert with the button still held → `press_pulse` 6 cycles later.
- **Active-high variant:** `BTN_ACTIVE_LOW`=0 with the reset pin level 0 → no press reported out of reset. Hold `btn_raw`=1 for 6 cycles → one `press_pulse`.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared constants, FSM encodings and event payload for the push-button input path.
package button_conditioner_pkg;

    localparam int unsigned CLK_HZ                    = 27_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES   = 270_000;     // 10 ms at CLK_HZ
    localparam int unsigned DEFAULT_LONG_PRESS_CYCLES = 13_500_000;  // 500 ms at CLK_HZ

    localparam int unsigned STATE_W = 2;

    localparam logic [1:0] ST_RELEASED    = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
    localparam logic [1:0] ST_PRESSED     = 2'd2;
    localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic long_pulse;
        logic long_press;
    } btn_events_t;

    // The debounced level is pressed whenever the FSM holds an accepted press.
    function automatic logic is_held(input logic [STATE_W-1:0] st);
        return (st == ST_PRESSED) || (st == ST_RELEASE_CHK);
    endfunction

endpackage

// File: rtl/button_conditioner_sync.sv
// Generic 1-bit two-flop synchroniser with a parameterised reset value.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Synchronises and debounces the raw button pin; emits level, press/release/long strobes.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
    parameter bit          BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic long_press
);

    localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HCNT_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_PRESS_CYCLES);

    logic                sync_q;
    logic                p;
    logic [STATE_W-1:0]  state;
    logic [STATE_W-1:0]  state_nxt;
    logic [DCNT_W-1:0]   dcnt;
    logic [DCNT_W-1:0]   dcnt_nxt;
    logic [HCNT_W-1:0]   hcnt;
    logic [HCNT_W-1:0]   hcnt_nxt;
    logic                hold_run;
    btn_events_t         evt;
    btn_events_t         evt_nxt;

    // Flops reset to the released pin level so reset can never look like a press.
    sync_2ff #(
        .RST_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_raw),
        .q     (sync_q)
    );

    assign p = sync_q ^ BTN_ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RELEASED;
            dcnt  <= '0;
            hcnt  <= '0;
            evt   <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            hcnt  <= hcnt_nxt;
            evt   <= evt_nxt;
        end
    end

    always_comb begin
        state_nxt           = state;
        dcnt_nxt            = dcnt;
        hcnt_nxt            = hcnt;
        hold_run            = 1'b0;
        evt_nxt             = '0;
        evt_nxt.long_press  = evt.long_press;

        case (state)
            ST_RELEASED: begin
                if (p) begin
                    state_nxt = ST_PRESS_CHK;
                    dcnt_nxt  = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!p) begin
                    state_nxt = ST_RELEASED;
                end else if (dcnt == DCNT_LAST) begin
                    state_nxt     = ST_PRESSED;
                    evt_nxt.press = 1'b1;
                    hcnt_nxt      = '0;
                end else begin
                    dcnt_nxt = DCNT_W'(dcnt + 1'b1);
                end
            end
            ST_PRESSED: begin
                hold_run = 1'b1;
                if (!p) begin
                    state_nxt = ST_RELEASE_CHK;
                    dcnt_nxt  = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (p) begin
                    state_nxt = ST_PRESSED;
                    hold_run  = 1'b1;
                end else if (dcnt == DCNT_LAST) begin
                    // Accepted release ends the hold; it takes priority over the hold counter.
                    state_nxt          = ST_RELEASED;
                    evt_nxt.rel        = 1'b1;
                    evt_nxt.long_press = 1'b0;
                    hcnt_nxt           = '0;
                end else begin
                    dcnt_nxt = DCNT_W'(dcnt + 1'b1);
                    hold_run = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RELEASED;
            end
        endcase

        // Saturating hold counter; the strobe fires only on the step that reaches the limit.
        if (hold_run && (hcnt != HCNT_MAX)) begin
            hcnt_nxt = HCNT_W'(hcnt + 1'b1);
            if (hcnt_nxt == HCNT_MAX) begin
                evt_nxt.long_pulse = 1'b1;
                evt_nxt.long_press = 1'b1;
            end
        end

        evt_nxt.level = is_held(state_nxt);
    end

    assign btn_level     = evt.level;
    assign press_pulse   = evt.press;
    assign release_pulse = evt.rel;
    assign long_pulse    = evt.long_pulse;
    assign long_press    = evt.long_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: run-length reference model for the debouncer plus directed timing checks.
module tb_button_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned L = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic btn_raw = 1'b1;
    logic btn_raw_ah = 1'b0;

    logic btn_level, press_pulse, release_pulse, long_pulse, long_press;
    logic ah_level, ah_press, ah_release, ah_long_pulse, ah_long_press;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .BTN_ACTIVE_LOW    (1'b1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .long_press    (long_press)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .BTN_ACTIVE_LOW    (1'b0)
    ) dut_ah (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw_ah),
        .btn_level     (ah_level),
        .press_pulse   (ah_press),
        .release_pulse (ah_release),
        .long_pulse    (ah_long_pulse),
        .long_press    (ah_long_press)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level change is accepted after D+1 consecutive synchronised
    // samples that disagree with the current level; the pin reaches the decision two edges late.
    logic m_h0, m_h1, m_level, m_press, m_rel, m_lp, m_long;
    int   m_run, m_hold;

    always @(posedge clk or negedge rst_n) begin : model
        logic p, lvl, lg, pr, rl, lpu;
        int   r, hd;
        if (!rst_n) begin
            m_h0 <= 1'b1; m_h1 <= 1'b1;
            m_level <= 1'b0; m_press <= 1'b0; m_rel <= 1'b0; m_lp <= 1'b0; m_long <= 1'b0;
            m_run <= 0; m_hold <= 0;
        end else begin
            p = ~m_h1;
            lvl = m_level; lg = m_long; r = m_run; hd = m_hold;
            pr = 1'b0; rl = 1'b0; lpu = 1'b0;
            if (p != lvl) r = r + 1; else r = 0;
            if (r == int'(D) + 1) begin
                lvl = ~lvl; r = 0; hd = 0;
                if (lvl) pr = 1'b1;
                else begin rl = 1'b1; lg = 1'b0; end
            end else if (lvl && hd < int'(L)) begin
                hd = hd + 1;
                if (hd == int'(L)) begin lpu = 1'b1; lg = 1'b1; end
            end
            m_h1 <= m_h0; m_h0 <= btn_raw;
            m_level <= lvl; m_press <= pr; m_rel <= rl; m_lp <= lpu; m_long <= lg;
            m_run <= r; m_hold <= hd;
        end
    end

    // Every cycle: DUT outputs against the model, sampled away from the active edge.
    always @(negedge clk) begin
        chk("model_btn_level", btn_level, m_level);
        chk("model_press_pulse", press_pulse, m_press);
        chk("model_release_pulse", release_pulse, m_rel);
        chk("model_long_pulse", long_pulse, m_lp);
        chk("model_long_press", long_press, m_long);
    end

    initial begin : stim
        int any_out, cnt, rel_seen, lvl_drop, len;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_level", btn_level, 1'b0);
        chk("rst_press", press_pulse, 1'b0);
        chk("rst_release", release_pulse, 1'b0);
        chk("rst_long_pulse", long_pulse, 1'b0);
        chk("rst_long_press", long_press, 1'b0);
        rst_n = 1'b1;

        // Active-high variant: pin idles low, no press out of reset
        any_out = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ah_level | ah_press | ah_release | ah_long_pulse | ah_long_press) any_out++;
        end
        chk_int("ah_idle_outputs", any_out, 0);
        btn_raw_ah = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 6) chk("ah_press_early", ah_press, 1'b0);
            if (k == 7) chk("ah_press_edge", ah_press, 1'b1);
            if (ah_press) cnt++;
        end
        chk_int("ah_press_count", cnt, 1);
        btn_raw_ah = 1'b0;
        repeat (10) @(negedge clk);

        // Clean press, release glitch mid-hold, long press, clean release
        btn_raw = 1'b0;
        rel_seen = 0; lvl_drop = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 6) chk("press_early", press_pulse, 1'b0);
            if (k == 7) begin
                chk("press_edge", press_pulse, 1'b1);
                chk("press_level", btn_level, 1'b1);
                chk("press_no_long", long_pulse, 1'b0);
            end
            if (k == 8) chk("press_width", press_pulse, 1'b0);
            if (k == 26) chk("long_early", long_pulse, 1'b0);
            if (k == 27) chk("long_edge", long_pulse, 1'b1);
            if (k == 28) begin
                chk("long_width", long_pulse, 1'b0);
                chk("long_level", long_press, 1'b1);
            end
            if (k >= 7 && !btn_level) lvl_drop++;
            if (release_pulse) rel_seen++;
            if (k == 10) btn_raw = 1'b1;
            if (k == 13) btn_raw = 1'b0;
        end
        chk_int("glitch_no_release", rel_seen, 0);
        chk_int("glitch_level_held", lvl_drop, 0);
        btn_raw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) chk("release_early", release_pulse, 1'b0);
            if (k == 7) begin
                chk("release_edge", release_pulse, 1'b1);
                chk("release_clears_long", long_press, 1'b0);
                chk("release_level", btn_level, 1'b0);
            end
            if (k == 8) chk("release_width", release_pulse, 1'b0);
        end

        // Bounce rejection: toggle every 2 cycles, then settle released
        any_out = 0;
        for (int k = 0; k < 50; k++) begin
            if (k < 40) btn_raw = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
            else btn_raw = 1'b1;
            @(negedge clk);
            if (btn_level | press_pulse | release_pulse | long_pulse | long_press) any_out++;
        end
        chk_int("bounce_outputs", any_out, 0);

        // Reset while long-pressed, then release reset with the button still held
        btn_raw = 1'b0;
        repeat (32) @(negedge clk);
        chk("pre_reset_long", long_press, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_level", btn_level, 1'b0);
        chk("async_rst_press", press_pulse, 1'b0);
        chk("async_rst_release", release_pulse, 1'b0);
        chk("async_rst_long_pulse", long_pulse, 1'b0);
        chk("async_rst_long_press", long_press, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rel_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 6) chk("rearm_press_early", press_pulse, 1'b0);
            if (k == 7) chk("rearm_press_edge", press_pulse, 1'b1);
            if (release_pulse) rel_seen++;
        end
        chk_int("rearm_no_release", rel_seen, 0);
        btn_raw = 1'b1;
        repeat (12) @(negedge clk);

        // Randomised bouncy pin activity against the model, with one reset in the middle
        for (int s = 0; s < 160; s++) begin
            btn_raw = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45)) : int'($urandom_range(1, 7));
            repeat (len) @(negedge clk);
            if (s == 80) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        btn_raw = 1'b1;
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
